// File: rtl/add_seq_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package add_seq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } state_e;

   function automatic int unsigned num_digits(input int unsigned width,
                                              input int unsigned digit_w);
      return (digit_w == 0) ? 0 : width / digit_w;
   endfunction

   // A single-digit configuration still needs a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DefaultWidth  = 8;
   localparam int unsigned DefaultDigitW = 1;
   localparam int unsigned DefaultCntW   = cnt_width(num_digits(DefaultWidth, DefaultDigitW));

endpackage

// File: rtl/add_digit.sv
// DIGIT_W-bit full-adder slice; the only adder in the serial datapath.
module add_digit #(
   parameter int unsigned DIGIT_W = 1
) (
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               cin,
   output logic [DIGIT_W-1:0] s,
   output logic               cout
);

   logic [DIGIT_W:0] sum;

   assign sum  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
   assign s    = sum[DIGIT_W-1:0];
   assign cout = sum[DIGIT_W];

endmodule

// File: rtl/add_8bit_seq.sv
// Digit-serial adder {C_out, S} = A + B + C_in with valid/ready handshakes.
// Define ADD_SIGNED_OVF_EN to add the registered signed-overflow output V.
module add_8bit_seq
   import add_seq_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DIGIT_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
`ifdef ADD_SIGNED_OVF_EN
   output logic             C_out,
   output logic             V
`else
   output logic             C_out
`endif
);

   localparam int unsigned N    = num_digits(WIDTH, DIGIT_W);
   localparam int unsigned CntW = cnt_width(N);
   localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

   if ((DIGIT_W == 0) || ((WIDTH % DIGIT_W) != 0)) begin : g_bad_cfg
      $error("add_8bit_seq: DIGIT_W must be nonzero and divide WIDTH");
   end

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
`ifdef ADD_SIGNED_OVF_EN
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             v_q, v_d;
`endif

   logic [DIGIT_W-1:0] dig_s;
   logic               dig_c;
   logic [WIDTH-1:0]   res_shift;

   add_digit #(
      .DIGIT_W(DIGIT_W)
   ) u_add_digit (
      .a   (a_q[DIGIT_W-1:0]),
      .b   (b_q[DIGIT_W-1:0]),
      .cin (carry_q),
      .s   (dig_s),
      .cout(dig_c)
   );

   // Digits enter at the MSB end so the first (LSB) digit lands at bit 0 after N shifts.
   if (DIGIT_W == WIDTH) begin : g_res_full
      assign res_shift = dig_s;
   end else begin : g_res_part
      assign res_shift = {dig_s, res_q[WIDTH-1:DIGIT_W]};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      res_d   = res_q;
      s_d     = s_q;
      cout_d  = cout_q;
`ifdef ADD_SIGNED_OVF_EN
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      v_d     = v_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = A;
               b_d     = B;
               carry_d = C_in;
               cnt_d   = '0;
`ifdef ADD_SIGNED_OVF_EN
               a_msb_d = A[WIDTH-1];
               b_msb_d = B[WIDTH-1];
`endif
               state_d = StCalc;
            end
         end
         StCalc: begin
            a_d     = a_q >> DIGIT_W;
            b_d     = b_q >> DIGIT_W;
            carry_d = dig_c;
            res_d   = res_shift;
            cnt_d   = cnt_q + CntW'(1);
            // Outputs only update on completion so they stay stable during CALC.
            if (cnt_q == LastCnt) begin
               s_d     = res_shift;
               cout_d  = dig_c;
`ifdef ADD_SIGNED_OVF_EN
               v_d     = (a_msb_q == b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
`endif
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
`ifdef ADD_SIGNED_OVF_EN
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         v_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
`ifdef ADD_SIGNED_OVF_EN
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         v_q     <= v_d;
`endif
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign S         = s_q;
   assign C_out     = cout_q;
`ifdef ADD_SIGNED_OVF_EN
   assign V         = v_q;
`endif

endmodule

// File: tb/tb_add_8bit_seq.sv
// Directed self-checking bench for add_8bit_seq (default WIDTH=8, DIGIT_W=1).
module tb_add_8bit_seq;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] A;
   logic [7:0] B;
   logic       C_in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] S;
   logic       C_out;
`ifdef ADD_SIGNED_OVF_EN
   logic       V;
`endif

   int checks;
   int errors;

   add_8bit_seq u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (A),
      .B        (B),
      .C_in     (C_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .S        (S),
`ifdef ADD_SIGNED_OVF_EN
      .C_out    (C_out),
      .V        (V)
`else
      .C_out    (C_out)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Presents one operand set in IDLE, then counts edges until out_valid (bounded).
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output int lat);
      A        = a;
      B        = b;
      C_in     = cin;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat      = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
      end
      checks++;
      if (S !== 8'd0 || C_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: S=%0d C_out=%b, required 0/0", S, C_out);
      end
`ifdef ADD_SIGNED_OVF_EN
      checks++;
      if (V !== 1'b0) begin
         errors++;
         $display("FAIL reset_v: V=%b, required 0", V);
      end
`endif
   endtask

   task automatic test_basic();
      int lat;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_ready: in_ready=%b, required 1", in_ready);
      end
      do_op(8'd100, 8'd27, 1'b0, lat);
      checks++;
      if (lat != 8) begin
         errors++;
         $display("FAIL basic_latency: edges=%0d, required 8", lat);
      end
      checks++;
      if (S !== 8'd127 || C_out !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: S=%0d C_out=%b in_ready=%b, required 127/0/0",
                  S, C_out, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || S !== 8'd127) begin
         errors++;
         $display("FAIL basic_drop: out_valid=%b in_ready=%b S=%0d, required 0/1/127",
                  out_valid, in_ready, S);
      end
   endtask

   task automatic test_vectors();
      logic [7:0] va  [5] = '{8'd200, 8'd255, 8'd0, 8'd255, 8'h55};
      logic [7:0] vb  [5] = '{8'd100, 8'd0,   8'd0, 8'd255, 8'hAA};
      logic       vc  [5] = '{1'b0,   1'b1,   1'b0, 1'b1,   1'b0};
      logic [7:0] es  [5] = '{8'd44,  8'd0,   8'd0, 8'd255, 8'hFF};
      logic       ec  [5] = '{1'b1,   1'b1,   1'b0, 1'b1,   1'b0};
      int lat;
      for (int i = 0; i < 5; i++) begin
         do_op(va[i], vb[i], vc[i], lat);
         checks++;
         if (lat != 8 || S !== es[i] || C_out !== ec[i]) begin
            errors++;
            $display("FAIL vector_%0d: lat=%0d S=%0d C_out=%b, required 8/%0d/%b",
                     i, lat, S, C_out, es[i], ec[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_hold();
      int lat;
      out_ready = 1'b0;
      A         = 8'd10;
      B         = 8'd20;
      C_in      = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      // Keep in_valid high with new operands through CALC and DONE; both must be ignored.
      A    = 8'd99;
      B    = 8'd99;
      C_in = 1'b0;
      lat  = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat != 8 || S !== 8'd31 || C_out !== 1'b0) begin
         errors++;
         $display("FAIL hold_result: lat=%0d S=%0d C_out=%b, required 8/31/0", lat, S, C_out);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || S !== 8'd31 || C_out !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle_%0d: out_valid=%b in_ready=%b S=%0d C_out=%b, required 1/0/31/0",
                     i, out_valid, in_ready, S, C_out);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || S !== 8'd31) begin
         errors++;
         $display("FAIL hold_release: out_valid=%b in_ready=%b S=%0d, required 0/1/31",
                  out_valid, in_ready, S);
      end
   endtask

   task automatic test_mid_reset();
      int lat;
      A        = 8'd50;
      B        = 8'd60;
      C_in     = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || S !== 8'd0 || C_out !== 1'b0) begin
         errors++;
         $display("FAIL midrst_state: in_ready=%b out_valid=%b S=%0d C_out=%b, required 1/0/0/0",
                  in_ready, out_valid, S, C_out);
      end
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid) lat++;
      end
      checks++;
      if (lat != 0) begin
         errors++;
         $display("FAIL midrst_no_valid: out_valid cycles=%0d, required 0", lat);
      end
      do_op(8'd1, 8'd1, 1'b0, lat);
      checks++;
      if (lat != 8 || S !== 8'd2 || C_out !== 1'b0) begin
         errors++;
         $display("FAIL midrst_fresh: lat=%0d S=%0d C_out=%b, required 8/2/0", lat, S, C_out);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_inverse();
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       exp_c;
      int lat;
      for (int i = 0; i < 100; i++) begin
         a     = 8'($urandom_range(0, 255));
         b     = 8'($urandom_range(0, 255));
         d     = a - b;
         exp_c = (a < b) ? 1'b1 : 1'b0;
         do_op(d, b, 1'b0, lat);
         checks++;
         if (lat != 8 || S !== a || C_out !== exp_c) begin
            errors++;
            $display("FAIL inverse_%0d: D=%0d B=%0d lat=%0d S=%0d C_out=%b, required 8/%0d/%b",
                     i, d, b, lat, S, C_out, a, exp_c);
         end
         @(posedge clk); #1;
      end
   endtask

`ifdef ADD_SIGNED_OVF_EN
   task automatic test_ovf();
      logic [7:0] va [3] = '{8'd100, 8'h80, 8'h7F};
      logic [7:0] vb [3] = '{8'd100, 8'h80, 8'h81};
      logic [7:0] es [3] = '{8'd200, 8'h00, 8'h00};
      logic       ec [3] = '{1'b0,   1'b1,  1'b1};
      logic       ev [3] = '{1'b1,   1'b1,  1'b0};
      int lat;
      for (int i = 0; i < 3; i++) begin
         do_op(va[i], vb[i], 1'b0, lat);
         checks++;
         if (lat != 8 || S !== es[i] || C_out !== ec[i] || V !== ev[i]) begin
            errors++;
            $display("FAIL ovf_%0d: lat=%0d S=%0d C_out=%b V=%b, required 8/%0d/%b/%b",
                     i, lat, S, C_out, V, es[i], ec[i], ev[i]);
         end
         @(posedge clk); #1;
      end
   endtask
`endif

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      A         = 8'd0;
      B         = 8'd0;
      C_in      = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_vectors();
      test_hold();
      test_mid_reset();
      test_inverse();
`ifdef ADD_SIGNED_OVF_EN
      test_ovf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/add_8bit_seq.md
Name: add_8bit_seq

Overview:
- Multi-cycle, digit-serial 8-bit adder. Computes S = A + B + C_in over WIDTH/DIGIT_W cycles.
- Inverse companion to the 8-bit subtractor in the arithmetic library: feeding the subtractor's difference D and subtrahend B recovers A.
- Operands enter and results leave through valid/ready handshakes, so the block slots into pipelined datapaths where a single-cycle carry chain would be too slow.

Parameters:
- WIDTH, 8, operand and result width in bits.
- DIGIT_W, 1, bits added per cycle. Must divide WIDTH; elaboration error otherwise.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands A, B, C_in are valid this cycle.
- in_ready  output  1  block can accept operands (high only in IDLE).
- A  input  WIDTH  augend.
- B  input  WIDTH  addend.
- C_in  input  1  carry-in.
- out_valid  output  1  S and C_out hold a completed result.
- out_ready  input  1  consumer accepts the result.
- S  output  WIDTH  sum, modulo 2^WIDTH.
- C_out  output  1  carry out of bit WIDTH-1.

Behaviour:
- N = WIDTH/DIGIT_W. States: IDLE, CALC, DONE.
- Reset (rst high at an edge):
  - State goes to IDLE and the digit counter clears.
  - in_ready=1 and out_valid=0 in the following cycle.
  - S=0 and C_out=0; operand registers clear.
- Reset overrides all other inputs, including mid-CALC and mid-DONE: the operation in flight is discarded and no out_valid is produced for it.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch A, B and C_in into shift registers, carry register = C_in, counter = 0, go to CALC.
- CALC:
  - in_ready=0; in_valid is ignored.
  - Each cycle: low DIGIT_W bits of A_sh + B_sh + carry.
  - Digit sum shifts into the result register from the MSB end; A_sh and B_sh shift right by DIGIT_W; carry register updates; counter increments.
  - When counter == N-1 at the edge, go to DONE.
- DONE:
  - out_valid=1; S and C_out are held stable.
  - On out_ready go to IDLE; with out_ready low, hold indefinitely.
- Latency: out_valid rises exactly N edges after the accepting edge (8 for the defaults).
- Throughput: one result per N+2 cycles at most; the handshakes never overlap.
- out_valid and in_ready are never high in the same cycle.
- S and C_out:
  - Retain the last completed result in IDLE.
  - Are undefined-but-stable while in CALC.
  - Are only meaningful while out_valid=1.
- Arithmetic:
  - Unsigned: {C_out, S} = A + B + C_in, exact to WIDTH+1 bits.
  - Wrap-around: 255+1 gives S=0, C_out=1.

Optional Feature:
- Macro: ADD_SIGNED_OVF_EN.
- When defined:
  - Extra output port V (1 bit).
  - V = (A[WIDTH-1] == B[WIDTH-1]) && (S[WIDTH-1] != A[WIDTH-1]), evaluated on the latched operands.
  - V is registered alongside S, valid under out_valid, and resets to 0.
- When undefined: port V and its logic are absent; all other behaviour is identical.

Decomposition:
- Package add_seq_pkg holds:
  - State enum (IDLE, CALC, DONE).
  - Localparam N derivation helper.
  - Counter width constant $clog2(N).
- One combinational sub-module, add_digit: a DIGIT_W-bit full-adder slice with inputs a, b, cin and outputs s, cout, instantiated once in the datapath.

Test Plan:
- A=100, B=27, C_in=0, out_ready=1: S=127, C_out=0; out_valid rises 8 edges after acceptance and drops the cycle after the handshake.
- A=200, B=100, C_in=0: S=44, C_out=1. A=255, B=0, C_in=1: S=0, C_out=1 (wrap boundary).
- Hold out_ready=0 for 5 cycles in DONE: out_valid stays 1, S/C_out unchanged, in_ready stays 0. Pulsing in_valid during CALC/DONE has no effect.
- Assert rst at the 4th CALC cycle: next cycle in_ready=1, out_valid=0, S=0. A fresh op A=1, B=1 then completes with S=2.
- Inverse check, 100 random pairs: compute D=(A-B) mod 256, feed A'=D, B'=B, C_in=0; require S==A and C_out==(A<B)?1:0 (i.e. no borrow in A-B implies no carry out of D+B).
- With ADD_SIGNED_OVF_EN:
  - A=100, B=100 gives S=200, V=1.
  - A=0x80, B=0x80 gives S=0, C_out=1, V=1.
  - A=0x7F, B=0x81 gives S=0, V=0.
